// File: rtl/ext_pkg.sv
// Shared types for the immediate/load-data extender: mode encoding and
// skid-buffer occupancy states.
package ext_pkg;

   typedef enum logic [2:0] {
      SEXT     = 3'b000,
      ZEXT     = 3'b001,
      HIGH     = 3'b010,
      SEXT_SHL = 3'b011,
      LB       = 3'b100,
      LBU      = 3'b101,
      LH       = 3'b110,
      LHU      = 3'b111
   } ext_mode_e;

   typedef enum logic [1:0] {
      S_EMPTY = 2'b00,
      S_ONE   = 2'b01,
      S_TWO   = 2'b10
   } skid_state_e;

endpackage

// File: rtl/ext_core.sv
// Combinational extender: immediate sign/zero/high/shifted extension and
// byte/half load extraction with half-word misalignment detection.
module ext_core
   import ext_pkg::*;
#(
   parameter  int IMM_W  = 16,
   parameter  int DATA_W = 32,
   parameter  int SHIFT  = 2,
   localparam int OFF_W  = $clog2(DATA_W / 8)
) (
   input  ext_mode_e         mode,
   input  logic [DATA_W-1:0] data,
   input  logic [OFF_W-1:0]  off,
   output logic [DATA_W-1:0] result,
   output logic              misalign
);

   localparam int PAD = DATA_W - IMM_W;

   logic [IMM_W-1:0]  imm;
   logic [DATA_W-1:0] sext;
   logic [7:0]        lbyte;
   logic [15:0]       lhalf;
   logic              half_bad;

   always_comb begin
      imm      = data[IMM_W-1:0];
      sext     = {{PAD{imm[IMM_W-1]}}, imm};
      lbyte    = 8'(data >> {off, 3'b000});
      lhalf    = 16'(data >> {off, 3'b000});
      // odd offset, or a half that would run past the top of the word
      half_bad = off[0] || (int'(off) > (DATA_W / 8 - 2));
      result   = '0;
      misalign = 1'b0;
      unique case (mode)
         SEXT:     result = sext;
         ZEXT:     result = {{PAD{1'b0}}, imm};
         HIGH:     result = {imm, {PAD{1'b0}}};
         SEXT_SHL: result = sext << SHIFT;
         LB:       result = {{(DATA_W-8){lbyte[7]}}, lbyte};
         LBU:      result = {{(DATA_W-8){1'b0}}, lbyte};
         LH: begin
            if (half_bad) misalign = 1'b1;
            else          result   = {{(DATA_W-16){lhalf[15]}}, lhalf};
         end
         LHU: begin
            if (half_bad) misalign = 1'b1;
            else          result   = {{(DATA_W-16){1'b0}}, lhalf};
         end
      endcase
   end

endmodule

// File: rtl/ext_pipe.sv
// Registered valid/ready stage around ext_core with a two-entry skid buffer;
// in_ready is a flop so out_ready never reaches it combinationally.
module ext_pipe
   import ext_pkg::*;
#(
   parameter  int IMM_W  = 16,
   parameter  int DATA_W = 32,
   parameter  int SHIFT  = 2,
   localparam int OFF_W  = $clog2(DATA_W / 8)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_mode,
   input  logic [DATA_W-1:0] in_data,
   input  logic [OFF_W-1:0]  in_off,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_misalign,
   output logic [15:0]       out_cnt
);

   logic [DATA_W-1:0] res;
   logic              res_mis;

   ext_core #(
      .IMM_W  (IMM_W),
      .DATA_W (DATA_W),
      .SHIFT  (SHIFT)
   ) u_core (
      .mode     (ext_mode_e'(in_mode)),
      .data     (in_data),
      .off      (in_off),
      .result   (res),
      .misalign (res_mis)
   );

   skid_state_e       state_q, state_d;
   logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
   logic              main_mis_q, main_mis_d, skid_mis_q, skid_mis_d;
   logic              in_ready_q, in_ready_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              accept, xfer;

   always_comb begin
      accept      = in_valid && in_ready_q;
      xfer        = (state_q != S_EMPTY) && out_ready;
      state_d     = state_q;
      main_data_d = main_data_q;
      main_mis_d  = main_mis_q;
      skid_data_d = skid_data_q;
      skid_mis_d  = skid_mis_q;
      unique case (state_q)
         S_EMPTY: if (accept) begin
            state_d     = S_ONE;
            main_data_d = res;
            main_mis_d  = res_mis;
         end
         S_ONE: begin
            if (accept && xfer) begin
               main_data_d = res;
               main_mis_d  = res_mis;
            end else if (accept) begin
               state_d     = S_TWO;
               skid_data_d = res;
               skid_mis_d  = res_mis;
            end else if (xfer) begin
               state_d = S_EMPTY;
            end
         end
         S_TWO: if (xfer) begin
            state_d     = S_ONE;
            main_data_d = skid_data_q;
            main_mis_d  = skid_mis_q;
         end
         default: state_d = S_EMPTY;
      endcase
      if (flush) state_d = S_EMPTY;
      in_ready_d = (state_d != S_TWO);
      cnt_d      = xfer ? cnt_q + 16'd1 : cnt_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_EMPTY;
         main_data_q <= '0;
         main_mis_q  <= 1'b0;
         skid_data_q <= '0;
         skid_mis_q  <= 1'b0;
         in_ready_q  <= 1'b1;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_mis_q  <= main_mis_d;
         skid_data_q <= skid_data_d;
         skid_mis_q  <= skid_mis_d;
         in_ready_q  <= in_ready_d;
         cnt_q       <= cnt_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = (state_q != S_EMPTY);
   assign out_data     = main_data_q;
   assign out_misalign = main_mis_q;
   assign out_cnt      = cnt_q;

endmodule

// File: tb/tb_ext_pipe.sv
// Directed plus randomized bench for ext_pipe against a FIFO reference model.
module tb_ext_pipe;

   localparam longint M32 = 64'sh1_0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [2:0]  in_mode = '0;
   logic [31:0] in_data = '0;
   logic [1:0]  in_off = '0;
   logic        in_ready, out_valid, out_misalign;
   logic [31:0] out_data;
   logic [15:0] out_cnt;

   ext_pipe #(.IMM_W(16), .DATA_W(32), .SHIFT(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_mode      (in_mode),
      .in_data      (in_data),
      .in_off       (in_off),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_misalign (out_misalign),
      .out_cnt      (out_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] d;
      logic        m;
   } exp_t;

   exp_t        q[$];
   logic [15:0] cnt_m = '0;
   int          errors = 0;
   int          checks = 0;
   bit          quiet = 1'b0;
   int unsigned xfers = 0;
   logic [15:0] cnt_before;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] wrap32(input longint v);
      return 32'(((v % M32) + M32) % M32);
   endfunction

   // Reference extension from plain arithmetic on the word value
   function automatic exp_t ref_ext(input logic [2:0] m, input logic [31:0] d, input int off);
      exp_t   e;
      longint du, imm, simm, pw, b, h;
      du   = longint'(d);
      imm  = du % 65536;
      simm = (imm >= 32768) ? imm - 65536 : imm;
      pw   = 1;
      for (int i = 0; i < off; i++) pw = pw * 256;
      b    = (du / pw) % 256;
      h    = (du / pw) % 65536;
      e.m  = 1'b0;
      e.d  = '0;
      case (m)
         3'd0: e.d = wrap32(simm);
         3'd1: e.d = wrap32(imm);
         3'd2: e.d = wrap32(imm * 65536);
         3'd3: e.d = wrap32(simm * 4);
         3'd4: e.d = wrap32((b >= 128) ? b - 256 : b);
         3'd5: e.d = wrap32(b);
         default: begin
            if ((off % 2) == 1 || off * 8 + 16 > 32) e.m = 1'b1;
            else if (m == 3'd6) e.d = wrap32((h >= 32768) ? h - 65536 : h);
            else e.d = wrap32(h);
         end
      endcase
      return e;
   endfunction

   // Check outputs against the model, then advance model and DUT one edge
   task automatic tick();
      bit acc, xf;
      if (!quiet) begin
         chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
         chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
         chk("out_cnt", 32'(out_cnt), 32'(cnt_m));
         if (q.size() > 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_misalign", 32'(out_misalign), 32'(q[0].m));
         end
      end
      acc = in_valid && (q.size() < 2);
      xf  = out_ready && (q.size() > 0);
      if (xf) begin
         void'(q.pop_front());
         cnt_m++;
         xfers++;
      end
      if (flush) q.delete();
      else if (acc) q.push_back(ref_ext(in_mode, in_data, int'(in_off)));
      @(posedge clk);
      #1;
   endtask

   task automatic single(input string tag, input logic [2:0] m, input logic [31:0] d,
                         input logic [1:0] off, input logic [31:0] ed, input logic em);
      in_mode   = m;
      in_data   = d;
      in_off    = off;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk(tag, out_data, ed);
      chk({tag, "_mis"}, 32'(out_misalign), 32'(em));
      tick();
   endtask

   task automatic push(input logic [31:0] d);
      in_mode  = 3'd1;
      in_data  = d;
      in_valid = 1'b1;
      tick();
   endtask

   initial begin
      #1 reset = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_misalign", 32'(out_misalign), 32'd0);
      chk("rst_cnt", 32'(out_cnt), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;

      single("sext_8001", 3'd0, 32'h5A5A_8001, 2'd0, 32'hFFFF_8001, 1'b0);
      chk("cnt_first", 32'(out_cnt), 32'd1);
      single("sext", 3'd0, 32'h0000_9234, 2'd0, 32'hFFFF_9234, 1'b0);
      single("zext", 3'd1, 32'h0000_9234, 2'd0, 32'h0000_9234, 1'b0);
      single("high", 3'd2, 32'h0000_9234, 2'd0, 32'h9234_0000, 1'b0);
      single("sext_shl", 3'd3, 32'h0000_9234, 2'd0, 32'hFFFE_48D0, 1'b0);
      single("lb_off2", 3'd4, 32'h80FF_7F01, 2'd2, 32'hFFFF_FFFF, 1'b0);
      single("lbu_off3", 3'd5, 32'h80FF_7F01, 2'd3, 32'h0000_0080, 1'b0);
      single("lh_off0", 3'd6, 32'h80FF_7F01, 2'd0, 32'h0000_7F01, 1'b0);
      single("lhu_off2", 3'd7, 32'h80FF_7F01, 2'd2, 32'h0000_80FF, 1'b0);
      single("lh_off1", 3'd6, 32'h80FF_7F01, 2'd1, 32'h0000_0000, 1'b1);
      single("lhu_off3", 3'd7, 32'h80FF_7F01, 2'd3, 32'h0000_0000, 1'b1);

      // back-pressure: A, B fill the buffer, C waits
      out_ready = 1'b0;
      in_off    = 2'd0;
      push(32'h1111);
      push(32'h2222);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      push(32'h3333);
      push(32'h3333);
      chk("bp_hold_a", out_data, 32'h1111);
      out_ready = 1'b1;
      tick();
      chk("bp_order_b", out_data, 32'h2222);
      tick();
      chk("bp_order_c", out_data, 32'h3333);
      in_valid = 1'b0;
      tick();
      chk("bp_drained", 32'(out_valid), 32'd0);

      // flush in TWO, no coincident transfer
      out_ready = 1'b0;
      push(32'h4444);
      push(32'h5555);
      cnt_before = cnt_m;
      flush = 1'b1;
      push(32'h6666);
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_cnt", 32'(out_cnt), 32'(cnt_before));
      tick();

      // flush in TWO with a coincident transfer
      push(32'h7777);
      push(32'h8888);
      cnt_before = cnt_m;
      flush     = 1'b1;
      out_ready = 1'b1;
      push(32'h9999);
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_xfer_valid", 32'(out_valid), 32'd0);
      chk("flush_xfer_cnt", 32'(out_cnt), 32'(cnt_before + 16'd1));
      tick();

      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         in_mode   = 3'($urandom);
         in_data   = $urandom;
         in_off    = 2'($urandom);
         tick();
      end
      flush = 1'b0;

      // asynchronous reset between edges with both entries full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_mode   = 3'd0;
      in_data   = 32'h0000_F00D;
      tick();
      tick();
      #3 reset = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      chk("arst_out_data", out_data, 32'd0);
      chk("arst_misalign", 32'(out_misalign), 32'd0);
      chk("arst_cnt", 32'(out_cnt), 32'd0);
      q.delete();
      cnt_m = '0;
      @(posedge clk);
      #1 reset = 1'b1;
      in_valid = 1'b0;
      tick();

      // counter rollover over 65536 back-to-back transfers
      quiet     = 1'b1;
      xfers     = 0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_mode   = 3'd1;
      for (int i = 0; i < 70000 && xfers < 65535; i++) tick();
      quiet = 1'b0;
      chk("cnt_ffff", 32'(out_cnt), 32'h0000_FFFF);
      tick();
      chk("cnt_wrap", 32'(out_cnt), 32'd0);
      in_valid = 1'b0;
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
